// File: rtl/sign_num_dec_acc_pkg.sv
// Shared types and helpers for the sign-magnitude decoder / accumulator.
package sign_num_pkg;

    localparam int MAG_W = 14;
    localparam int DEC_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } dec_st_e;

    // Restore a signed product from its magnitude and combined sign;
    // a zero magnitude with sign set comes out as plain zero.
    function automatic logic signed [DEC_W-1:0] sm_to_tc(
        input logic [MAG_W-1:0] mag,
        input logic             sign
    );
        logic signed [DEC_W-1:0] m;
        m = $signed({1'b0, mag});
        return sign ? -m : m;
    endfunction

endpackage

// File: rtl/sign_num_dec_acc_dec_stage.sv
// Stage-1 register: decodes sign-magnitude beats into 15-bit two's complement.
module sign_num_dec_stage
    import sign_num_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAG_W-1:0]        mag_in,
    input  logic                    sign_a,
    input  logic                    sign_b,
    input  logic                    in_last,
    input  logic                    dec_ready,
    output logic                    dec_vld,
    output logic signed [DEC_W-1:0] dec_val,
    output logic                    dec_last
);

    assign in_ready = dec_ready;

    // Load a new decoded beat whenever the stage is allowed to advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_vld  <= 1'b0;
            dec_val  <= '0;
            dec_last <= 1'b0;
        end else if (dec_ready) begin
            dec_vld <= in_valid;
            if (in_valid) begin
                dec_val  <= sm_to_tc(mag_in, sign_a ^ sign_b);
                dec_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/sign_num_dec_acc.sv
// Sign-magnitude decoder plus dot-product accumulator with valid/ready output.
// Optional saturation: define SIGN_NUM_DEC_SAT_EN (adds the out_sat port).
module sign_num_dec_acc
    import sign_num_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W-1:0]   mag_in,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_cnt
`ifdef SIGN_NUM_DEC_SAT_EN
    ,
    output logic               out_sat
`endif
);

    logic                    dec_vld;
    logic signed [DEC_W-1:0] dec_val;
    logic                    dec_last;
    logic                    stall1;
    logic                    advance;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    dec_st_e                 st;
`ifdef SIGN_NUM_DEC_SAT_EN
    logic signed [ACC_W:0]   sum_w;
    logic                    sat_now;
    logic                    grp_sat;
`endif

    assign stall1  = dec_vld && dec_last && out_valid && !out_ready;
    assign advance = dec_vld && !stall1;

    sign_num_dec_stage u_dec (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag_in    (mag_in),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .in_last   (in_last),
        .dec_ready (!stall1),
        .dec_vld   (dec_vld),
        .dec_val   (dec_val),
        .dec_last  (dec_last)
    );

    // Next accumulator value: wrapping add, or clamped add when saturation is built in.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
`ifdef SIGN_NUM_DEC_SAT_EN
        sum_w   = (ACC_W+1)'(acc) + (ACC_W+1)'(dec_val);
        sat_now = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        if (sat_now)
            acc_nxt = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_nxt = sum_w[ACC_W-1:0];
`else
        acc_nxt = acc + ACC_W'(dec_val);
`endif
    end

    // Accumulate non-last beats; a last beat publishes the sum and restarts the group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
`ifdef SIGN_NUM_DEC_SAT_EN
            grp_sat   <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else begin
            if (advance && dec_last) begin
                out_data  <= acc_nxt;
                out_cnt   <= cnt_nxt;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
`ifdef SIGN_NUM_DEC_SAT_EN
                out_sat   <= grp_sat | sat_now;
                grp_sat   <= 1'b0;
`endif
            end else begin
                if (advance) begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
`ifdef SIGN_NUM_DEC_SAT_EN
                    grp_sat <= grp_sat | sat_now;
`endif
                end
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

    // Debug-only group state tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else if (stall1) begin
            st <= HOLD;
        end else begin
            case (st)
                IDLE:    if (advance && !dec_last) st <= ACCUM;
                ACCUM:   if (advance && dec_last)  st <= IDLE;
                HOLD:    if (out_ready)            st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule
